alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequential command front end for the 8-bit ALU datapath. Accepts operation commands on a valid/ready stream, drives the ALU's operand/select/subtract inputs from registers, samples the ALU result after a fixed settle cycle, and returns results through a small response FIFO with backpressure. Holds an accumulator so commands can chain on the previous result. Sits between the command source (test controller / future microsequencer) and the combinational ALU instance.

## Interface
- DEPTH, 4, response FIFO entries (power of two, ≥2)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command this cycle
- cmd_op  in  4  ALU select code
- cmd_sub  in  1  subtract control for add op
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_use_acc  in  1  1: use accumulator as A, ignore cmd_a
- alu_a, alu_b  out  8 each  registered operands to ALU
- alu_sel  out  4  registered select to ALU
- alu_sub  out  1  registered subtract to ALU
- alu_out  in  8  ALU result
- alu_carry  in  1  ALU carry out
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer takes head
- rsp_data  out  8  result
- rsp_carry  out  1  carry
- rsp_err  out  1  illegal opcode flag
- busy  out  1  state ≠ IDLE

## Operation
- Legal opcodes: 0000 add/sub, 0010 mul (low nibbles), 1000 and, 1001 or, 1010 xor, 1100 not, 0100 shl, 0101 shr. All others illegal.
- FSM: IDLE → ISSUE → SAMPLE → IDLE.
  - IDLE: cmd_ready = (count < DEPTH). On cmd_valid & cmd_ready: load alu_a (acc if cmd_use_acc else cmd_a), alu_b, alu_sel, alu_sub; latch illegal flag; go ISSUE.
  - ISSUE: ALU inputs held stable one full cycle (settle); go SAMPLE.
  - SAMPLE: push {alu_out, alu_carry, err} to FIFO; if err, push data 0, carry 0. If not err, acc ← alu_out. Go IDLE.
- cmd_ready low in ISSUE and SAMPLE. ALU inputs hold last values in IDLE (no toggling).
- FIFO: DEPTH entries, count 0..DEPTH, pointers wrap modulo DEPTH. Pop when rsp_valid & rsp_ready. Push and pop in same cycle: count unchanged, both pointers advance. Push never occurs with count = DEPTH (guaranteed by IDLE gating; only one command in flight).
- rsp_data/rsp_carry/rsp_err reflect FIFO head; stable while rsp_valid & !rsp_ready.
- Accumulator: 8 bits, updated only on legal-op SAMPLE; unchanged on illegal op.

## Timing
- Command accepted at edge T (cycle 0). alu_* valid after edge T. Sample at edge T+2. rsp_valid high after edge T+2 if FIFO was empty (response latency 3 cycles from acceptance edge to visible head, counting acceptance cycle).
- Max throughput: one command per 3 cycles.
- Next command accepted earliest at edge T+3.
- Reset (any state, including mid-ISSUE/SAMPLE): state IDLE, in-flight command discarded (no push), FIFO emptied, acc = 0, alu_a = alu_b = 0, alu_sel = 0000, alu_sub = 0, rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_err = 0, busy = 0. cmd_ready = 1 first cycle after reset release.
- cmd_ready may depend combinationally on state and count only, never on cmd_valid.

## Test plan
- Add: op 0000, sub 0, A=0xFF, B=0x01 → rsp_data 0x00, carry 1, err 0, three cycles after acceptance; A=0x7F,B=0x01 → 0x80, carry 0.
- Subtract and multiply: op 0000 sub 1, A=0x05, B=0x03 → 0x02, carry 1; op 0010, A=0x0F, B=0x0F → 0xE1, carry 0.
- Chain: add 0x10+0x20 (acc=0x30), then cmd_use_acc=1 op 0100 cmd_a=0xAA → 0x60; then illegal op 0011 → err 1, data 0, acc stays 0x60, next use_acc shr → 0x30.
- Backpressure: rsp_ready=0, issue 5 commands back-to-back → 4 accepted, rsp_valid=1, cmd_ready=0 after 4th SAMPLE; raise rsp_ready for one cycle → one pop, 5th command accepted, results emerge in order.
- Simultaneous push/pop: FIFO count 2, rsp_ready=1 during SAMPLE edge → count stays 2, order preserved across pointer wrap.
- Reset mid-op: assert rst during ISSUE → no response emitted, all outputs at reset values next cycle, acc = 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Command front end for the 8-bit combinational ALU. Accepts
//                one command at a time on a valid/ready stream, drives the
//                ALU inputs from registers, samples the result after one
//                settle cycle and queues {data, carry, err} in a small
//                response FIFO. An accumulator holds the last legal result
//                so that commands can chain on it.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic       cmd_sub,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  output logic       alu_sub,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       busy
);

  localparam int              c_aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]   c_depth_cnt = DEPTH[c_aw:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_cmd_ready;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_illegal;

  logic [7:0]      r_alu_a;
  logic [7:0]      r_alu_b;
  logic [3:0]      r_alu_sel;
  logic            r_alu_sub;
  logic            r_err;
  logic [7:0]      r_acc;

  logic [7:0]      r_mem_data  [DEPTH];
  logic            r_mem_carry [DEPTH];
  logic            r_mem_err   [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;

  // Opcode legality decode of the incoming command.
  always_comb begin
    w_illegal = 1'b1;
    case (cmd_op)
      4'b0000, 4'b0010, 4'b1000, 4'b1001,
      4'b1010, 4'b1100, 4'b0100, 4'b0101: w_illegal = 1'b0;
      default:                            w_illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; ready depends only on state and count.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = (r_count < c_depth_cnt);
        w_accept    = cmd_valid & w_cmd_ready;
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_push      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ALU operand registers: loaded on acceptance, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a   <= 8'h00;
      r_alu_b   <= 8'h00;
      r_alu_sel <= 4'h0;
      r_alu_sub <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_alu_a   <= cmd_use_acc ? r_acc : cmd_a;
      r_alu_b   <= cmd_b;
      r_alu_sel <= cmd_op;
      r_alu_sub <= cmd_sub;
      r_err     <= w_illegal;
    end
  end

  // Accumulator tracks the most recent legal result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= 8'h00;
    end else if (w_push && !r_err) begin
      r_acc <= alu_out;
    end
  end

  // FIFO storage; an illegal command stores a zeroed result.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= r_err ? 8'h00 : alu_out;
      r_mem_carry[r_wr_ptr] <= r_err ? 1'b0 : alu_carry;
      r_mem_err[r_wr_ptr]   <= r_err;
    end
  end

  assign w_pop = (r_count != '0) & rsp_ready;

  // FIFO pointers and occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign busy      = (r_state != S_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign alu_sub   = r_alu_sub;
  assign rsp_valid = (r_count != '0);
  // Head fields read as zero while empty so reset leaves them cleared.
  assign rsp_data  = rsp_valid ? r_mem_data[r_rd_ptr]  : 8'h00;
  assign rsp_carry = rsp_valid ? r_mem_carry[r_rd_ptr] : 1'b0;
  assign rsp_err   = rsp_valid ? r_mem_err[r_rd_ptr]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Self-checking bench for alu_op_sequencer. Provides a
//                behavioural ALU, a transaction-level reference model, a
//                directed scenario set and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'h0;
  logic       cmd_sub = 1'b0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_use_acc = 1'b0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic       alu_sub;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_carry, rsp_err, busy;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sub(cmd_sub), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_sub(alu_sub),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural combinational ALU; unused selects drive junk on purpose.
  logic [7:0] w_mul;
  assign w_mul = {4'h0, alu_a[3:0]} * {4'h0, alu_b[3:0]};
  always_comb begin
    alu_out   = 8'hA5;
    alu_carry = 1'b1;
    case (alu_sel)
      4'b0000: {alu_carry, alu_out} = alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1)
                                              : ({1'b0, alu_a} + {1'b0, alu_b});
      4'b0010: {alu_carry, alu_out} = {1'b0, w_mul};
      4'b1000: {alu_carry, alu_out} = {1'b0, alu_a & alu_b};
      4'b1001: {alu_carry, alu_out} = {1'b0, alu_a | alu_b};
      4'b1010: {alu_carry, alu_out} = {1'b0, alu_a ^ alu_b};
      4'b1100: {alu_carry, alu_out} = {1'b0, ~alu_a};
      4'b0100: {alu_carry, alu_out} = {alu_a[7], alu_a[6:0], 1'b0};
      4'b0101: {alu_carry, alu_out} = {alu_a[0], 1'b0, alu_a[7:1]};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed { logic [7:0] d; logic c; logic e; } rsp_t;

  function automatic rsp_t ref_calc(input int a, input int b, input int op, input bit sub);
    rsp_t r;
    int   v;
    bit   c;
    v   = 0;
    c   = 1'b0;
    r.e = 1'b0;
    case (op)
      0: begin
        if (sub) begin v = (a - b + 256) % 256; c = (a >= b); end
        else     begin v = (a + b) % 256;       c = (a + b) > 255; end
      end
      2:  v = (a % 16) * (b % 16);
      8:  v = a & b;
      9:  v = a | b;
      10: v = a ^ b;
      12: v = 255 - a;
      4:  begin v = (a * 2) % 256; c = (a >= 128); end
      5:  begin v = a / 2;         c = (a % 2) == 1; end
      default: r.e = 1'b1;
    endcase
    r.d = 8'(v);
    r.c = c;
    return r;
  endfunction

  rsp_t       m_q[$];
  rsp_t       m_pend;
  int         m_age = -1;   // cycles since acceptance, -1 when nothing in flight
  logic [7:0] m_acc = 8'h00, m_a = 8'h00, m_b = 8'h00;
  logic [3:0] m_sel = 4'h0;
  logic       m_sub = 1'b0;
  bit         m_post_rst = 1'b1;

  always begin
    bit pop;
    bit take;
    int opa;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_age = -1; m_acc = 8'h00; m_a = 8'h00; m_b = 8'h00;
      m_sel = 4'h0; m_sub = 1'b0; m_post_rst = 1'b1;
    end else begin
      pop  = (m_q.size() != 0) && rsp_ready;
      take = (m_age < 0) && (m_q.size() < DEPTH) && cmd_valid;
      if (pop) void'(m_q.pop_front());
      if (m_age == 1) begin
        m_q.push_back(m_pend);
        if (!m_pend.e) m_acc = m_pend.d;
        m_age = -1;
        m_post_rst = 1'b0;
      end else if (m_age == 0) begin
        m_age = 1;
      end
      if (take) begin
        opa    = cmd_use_acc ? int'(m_acc) : int'(cmd_a);
        m_a    = 8'(opa);
        m_b    = cmd_b;
        m_sel  = cmd_op;
        m_sub  = cmd_sub;
        m_pend = ref_calc(opa, int'(cmd_b), int'(cmd_op), cmd_sub);
        m_age  = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'((m_age < 0) && (m_q.size() < DEPTH)));
      chk("busy",      32'(busy),      32'(m_age >= 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_q.size() != 0));
      chk("alu_a",     32'(alu_a),     32'(m_a));
      chk("alu_b",     32'(alu_b),     32'(m_b));
      chk("alu_sel",   32'(alu_sel),   32'(m_sel));
      chk("alu_sub",   32'(alu_sub),   32'(m_sub));
      if (m_q.size() != 0) begin
        chk("rsp_data",  32'(rsp_data),  32'(m_q[0].d));
        chk("rsp_carry", 32'(rsp_carry), 32'(m_q[0].c));
        chk("rsp_err",   32'(rsp_err),   32'(m_q[0].e));
      end else if (m_post_rst) begin
        chk("rst_data",  32'(rsp_data),  32'h0);
        chk("rst_carry", 32'(rsp_carry), 32'h0);
        chk("rst_err",   32'(rsp_err),   32'h0);
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [3:0] op, input logic sub, input logic [7:0] a,
                      input logic [7:0] b, input logic ua);
    int n;
    n = 0;
    cmd_op = op; cmd_sub = sub; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Response of the just-accepted command appears two edges later (empty FIFO).
  task automatic head_is(input string tag, input logic [7:0] d, input logic c, input logic e);
    repeat (2) @(negedge clk);
    chk({tag, "_v"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_d"}, 32'(rsp_data),  32'(d));
    chk({tag, "_c"}, 32'(rsp_carry), 32'(c));
    chk({tag, "_e"}, 32'(rsp_err),   32'(e));
  endtask

  task automatic pop_one;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy",  32'(busy),      32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Arithmetic and chaining
    send(4'b0000, 1'b0, 8'hFF, 8'h01, 1'b0); head_is("add_ff", 8'h00, 1'b1, 1'b0);
    send(4'b0000, 1'b0, 8'h7F, 8'h01, 1'b0); head_is("add_7f", 8'h80, 1'b0, 1'b0);
    send(4'b0000, 1'b1, 8'h05, 8'h03, 1'b0); head_is("sub",    8'h02, 1'b1, 1'b0);
    send(4'b0010, 1'b0, 8'h0F, 8'h0F, 1'b0); head_is("mul",    8'hE1, 1'b0, 1'b0);
    send(4'b0000, 1'b0, 8'h10, 8'h20, 1'b0); head_is("ch_add", 8'h30, 1'b0, 1'b0);
    send(4'b0100, 1'b0, 8'hAA, 8'h00, 1'b1); head_is("ch_shl", 8'h60, 1'b0, 1'b0);
    send(4'b0011, 1'b0, 8'h12, 8'h34, 1'b0); head_is("ch_ill", 8'h00, 1'b0, 1'b1);
    send(4'b0101, 1'b0, 8'hAA, 8'h00, 1'b1); head_is("ch_shr", 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Backpressure: four fill the FIFO, fifth waits for one pop
    for (int k = 1; k <= 4; k++) send(4'b0000, 1'b0, 8'h00, 8'(k), 1'b0);
    cmd_op = 4'b0000; cmd_sub = 1'b0; cmd_a = 8'h00; cmd_b = 8'h05; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_ready", 32'(cmd_ready), 32'h0);
    chk("bp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_head",  32'(rsp_data),  32'h1);
    pop_one();
    send(4'b0000, 1'b0, 8'h00, 8'h05, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 2; k <= 5; k++) begin
      chk("bp_order", 32'(rsp_data), 32'(k));
      pop_one();
    end
    chk("bp_empty", 32'(rsp_valid), 32'h0);

    // Simultaneous push and pop at count 2, across pointer wrap
    send(4'b0000, 1'b0, 8'h00, 8'h06, 1'b0); repeat (2) @(negedge clk);
    send(4'b0000, 1'b0, 8'h00, 8'h07, 1'b0); repeat (2) @(negedge clk);
    send(4'b0000, 1'b0, 8'h00, 8'h08, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("pp_head7", 32'(rsp_data), 32'h7);
    pop_one();
    chk("pp_head8", 32'(rsp_data), 32'h8);
    pop_one();
    chk("pp_empty", 32'(rsp_valid), 32'h0);

    // Reset while a command is in ISSUE and the FIFO holds an entry
    send(4'b0000, 1'b0, 8'h00, 8'h09, 1'b0); repeat (2) @(negedge clk);
    send(4'b0000, 1'b0, 8'h00, 8'h0A, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_valid", 32'(rsp_valid), 32'h0);
    chk("mr_busy",  32'(busy),      32'h0);
    chk("mr_alu_a", 32'(alu_a),     32'h0);
    chk("mr_alu_b", 32'(alu_b),     32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_noresp", 32'(rsp_valid), 32'h0);
    rsp_ready = 1'b1;
    send(4'b0000, 1'b0, 8'h55, 8'h11, 1'b1); head_is("mr_acc0", 8'h11, 1'b0, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 99) == 0);
      cmd_valid   = 1'($urandom_range(0, 1));
      cmd_op      = 4'($urandom_range(0, 15));
      cmd_sub     = 1'($urandom_range(0, 1));
      cmd_a       = 8'($urandom_range(0, 255));
      cmd_b       = 8'($urandom_range(0, 255));
      cmd_use_acc = 1'($urandom_range(0, 1));
      rsp_ready   = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("final_idle", 32'(busy), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
